pending_request_encoder: RTL
============================

Name: pending_request_encoder

Overview:
- Sequential counterpart of the team's enable-gated 1-to-2^N decoders: collects request pulses on 2^N one-hot lines into a pending register.
- Emits one binary index per served request on a valid/ready output channel, then clears that request.
- Used wherever decoded strobes must be turned back into an index stream, for example interrupt or event aggregation feeding a sequencer.

Parameters:
- N, default 2: index width. The block has 2^N request lines (default 4).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable. While 0, req_in is ignored.
- req_in  input  2^N  request pulses, one bit per index.
- idx_ready  input  1  consumer accepts idx_out.
- idx_out  output  N  encoded index of the served request.
- idx_valid  output  1  idx_out holds a valid index.
- pending  output  2^N  pending-request register, for debug and status.
- overflow  output  1  one-cycle pulse when a request hits an already-pending bit.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (async assert, sync release): pending=0, idx_out=0, idx_valid=0, overflow=0, FSM=IDLE. Any in-flight index is discarded.
- Capture: pending_next = (pending & ~clr_mask) | (en ? req_in : 0).
  - clr_mask is the one-hot bit of the index loaded this edge, or 0 if none is loaded.
  - Set wins over clear on the same bit in the same edge.
- Overflow: registered, high for one cycle when en=1 and (req_in & pending & ~clr_mask) != 0. The request is merged, not counted.
- Selection: prio_enc on the registered pending value. Default is fixed priority, lowest index first.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - If pending != 0: load idx_out = sel, set clr_mask = onehot(sel), idx_valid <= 1, go to HOLD.
  - Otherwise stay in IDLE with idx_valid = 0.
- HOLD:
  - idx_out and idx_valid are stable while idx_ready = 0.
  - On an edge with idx_ready = 1 and pending != 0: load the next sel, clear it, stay in HOLD. This gives back-to-back indices at 1 per cycle.
  - On an edge with idx_ready = 1 and pending == 0: idx_valid <= 0, go to IDLE. idx_out keeps its last value.
- Latency: req_in sampled at edge k sets pending at k. idx_valid rises at edge k+1 if the FSM is idle.
- The presented index is already removed from pending. A new request for that bit during HOLD re-pends it without overflow and is served again later.
- en=0 mid-operation: pending still drains and the handshake continues. Only capture is blocked.
- With all 2^N bits pending and idx_ready held at 1: 2^N consecutive valid cycles, then idx_valid falls.

Optional Feature:
- Macro: PENDING_REQUEST_ENCODER_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A pointer last (N bits, reset value 2^N-1) records the last loaded index.
  - The search starts at last+1 and wraps modulo 2^N.
  - The pointer updates only when an index is loaded.
- Undefined: fixed lowest-index-first priority and no pointer register. Port list is identical in both builds.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE=1'b0, HOLD=1'b1.
  - Default N.
  - The onehot(idx) helper function.
- One sub-module, prio_enc: combinational, parameter N.
  - Inputs: vector and start index.
  - Outputs: index and any-set flag.
  - With the feature undefined, start is tied to 0.

Test Plan (N=2):
- Reset: rst_n=0 mid-run, with idx_valid=1 and pending=4'b1100 -> idx_valid=0, pending=0, overflow=0 immediately. No index appears after release.
- Enable gating: en=0, req_in=4'b1111 for 1 cycle -> pending stays 0 and idx_valid stays 0 for 5 cycles.
- Basic encode: en=1, idx_ready=1, req_in=4'b1010 for 1 cycle -> idx_valid on the next edge with idx_out=1, then idx_out=3, then idx_valid=0. pending goes 1010 -> 1000 -> 0000.
- Backpressure and re-pend: idx_ready=0, req_in=4'b0100 -> idx_out=2 is held stable 5 cycles.
  - Pulse 4'b0100 again -> pending=0100, overflow=0.
  - Pulse 4'b0100 a third time -> overflow=1 for exactly one cycle.
  - Raise idx_ready -> idx_out=2 is delivered twice in total.
- Priority with req_in=4'b0011 held continuously and idx_ready=1:
  - Macro undefined -> idx_out=0 every cycle (bit 1 starves).
  - Macro defined -> 0,1,0,1...
- All pending, idx_ready=1, no further requests -> indices 0,1,2,3 on 4 consecutive cycles, then idx_valid=0.

Source files
------------

// File: rtl/pending_request_encoder_pkg.sv
// Shared types and helpers for pending_request_encoder: FSM encoding, default
// index width and the one-hot expansion used to clear a served request.
package pending_request_encoder_pkg;

    localparam int unsigned N_DEFAULT = 2;
    // Widest index the one-hot helper supports; N must not exceed this.
    localparam int unsigned N_MAX     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [(1 << N_MAX)-1:0] onehot(input logic [N_MAX-1:0] idx);
        logic [(1 << N_MAX)-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/pending_request_encoder_if.sv
// Index output channel of pending_request_encoder: valid/ready handshake
// carrying the N-bit index of the served request.
interface pending_request_encoder_if
    import pending_request_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic [N-1:0] idx_out;
    logic         idx_valid;
    logic         idx_ready;

    modport master (output idx_out, output idx_valid, input idx_ready);
    modport slave  (input idx_out, input idx_valid, output idx_ready);

endinterface

// File: rtl/pending_request_encoder_prio_enc.sv
// prio_enc: combinational search for the first set bit of vec, starting at
// index start and wrapping modulo 2^N.
module prio_enc #(
    parameter int N = 2
) (
    input  logic [(1 << N)-1:0] vec,
    input  logic [N-1:0]        start,
    output logic [N-1:0]        idx,
    output logic                any
);

    logic [N-1:0] probe;

    always_comb begin
        idx   = '0;
        any   = 1'b0;
        probe = '0;
        for (int i = 0; i < (1 << N); i++) begin
            probe = start + N'(i);
            if (!any && vec[probe]) begin
                idx = probe;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_request_encoder.sv
// Collects one-hot request pulses into a pending register and serves them as a
// stream of binary indices. Define PENDING_REQUEST_ENCODER_ROUND_ROBIN_EN for
// rotating priority; otherwise the lowest pending index always wins.
module pending_request_encoder
    import pending_request_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [(1 << N)-1:0]        req_in,
    pending_request_encoder_if.master  idx_if,
    output logic [(1 << N)-1:0]        pending,
    output logic                       overflow
);

    localparam int LINES = 1 << N;

    state_e           state, state_next;
    logic [N-1:0]     sel;
    logic [N-1:0]     start;
    logic             any;
    logic             load;
    logic [LINES-1:0] clr_mask;
    logic [LINES-1:0] pending_next;

    prio_enc #(.N(N)) u_prio_enc (
        .vec   (pending),
        .start (start),
        .idx   (sel),
        .any   (any)
    );

`ifdef PENDING_REQUEST_ENCODER_ROUND_ROBIN_EN
    logic [N-1:0] last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last <= '1;
        else if (load) last <= sel;
    end

    assign start = last + N'(1);
`else
    assign start = '0;
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of a combinational process gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (any) state_next = HOLD;
            HOLD: if (idx_if.idx_ready && !any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        idx_if.idx_valid = (state == HOLD);
        load             = any && ((state == IDLE) || idx_if.idx_ready);
        clr_mask         = load ? LINES'(onehot(N_MAX'(sel))) : '0;
    end

    // A fresh request on the bit being cleared this edge re-pends it.
    assign pending_next = (pending & ~clr_mask) | (en ? req_in : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending        <= '0;
            overflow       <= 1'b0;
            idx_if.idx_out <= '0;
        end else begin
            pending  <= pending_next;
            overflow <= en && |(req_in & pending & ~clr_mask);
            if (load) idx_if.idx_out <= sel;
        end
    end

endmodule
